// File: rtl/se_pkg.sv
// Shared definitions for the squeeze-excitation channel scaler.
// Holds the controller state encoding, the default fixed-point format and
// the output saturation limits used by se_channel_scale.
package se_pkg;

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    WAIT_SCALE = 2'd1,
    EMIT       = 2'd2
  } state_t;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FRAC_BITS      = 8;

  // Signed Q8.8 output range.
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

endpackage

// File: rtl/se_fmap_buffer.sv
// Feature-map frame buffer: simple dual-port RAM, one write port and one
// read port with a registered, enable-gated read (output holds while rd_en=0).
// Ports:
//   clk      - clock
//   wr_en    - write strobe, wr_addr/wr_data - write address and data
//   rd_en    - read enable, rd_addr - read address
//   rd_data  - read data, valid the cycle after rd_en
// Contents are intentionally not reset.
module se_fmap_buffer #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/se_channel_scale.sv
// Squeeze-excitation channel scaler. Buffers one channel-major feature map,
// collects one unsigned Q8.8 attention scale per channel, then streams the
// frame back out with every sample multiplied by its channel's scale
// (floor rounding, saturated to signed DATA_WIDTH).
// Ports:
//   clk, rst (async, active-low)
//   in_data/in_valid/in_ready          - feature-map samples, channel-major
//   scale_data/scale_valid/scale_ready - per-channel scales, channel 0 first
//   out_data/out_valid/out_ready       - scaled samples
//   sat_flag   - qualifies out_data that was clipped
//   frame_done - one-cycle pulse after the last output of a frame is taken
module se_channel_scale
  import se_pkg::*;
#(
  parameter int DATA_WIDTH  = se_pkg::DATA_WIDTH_DEF,
  parameter int FRAC_BITS   = se_pkg::FRAC_BITS,
  parameter int IN_CHANNELS = 16,
  parameter int IN_HEIGHT   = 8,
  parameter int IN_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] scale_data,
  input  logic                  scale_valid,
  output logic                  scale_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sat_flag,
  output logic                  frame_done
);

  localparam int PIX_PER_CH   = IN_HEIGHT * IN_WIDTH;
  localparam int TOTAL_PIXELS = IN_CHANNELS * PIX_PER_CH;
  localparam int AW  = $clog2(TOTAL_PIXELS);
  localparam int CW  = $clog2(TOTAL_PIXELS + 1);
  localparam int SW  = $clog2(IN_CHANNELS + 1);
  localparam int CHW = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int PW  = 2 * DATA_WIDTH + 1;

  localparam logic signed [PW-1:0] LIM_HI = PW'(SAT_MAX);
  localparam logic signed [PW-1:0] LIM_LO = PW'(SAT_MIN);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  flag;
  } sat_t;

  function automatic logic signed [PW-1:0] floor_shift(input logic signed [PW-1:0] v);
    return v >>> FRAC_BITS;
  endfunction

  function automatic sat_t saturate(input logic signed [PW-1:0] v);
    sat_t r;
    if (v > LIM_HI) begin
      r.data = DATA_WIDTH'(LIM_HI);
      r.flag = 1'b1;
    end else if (v < LIM_LO) begin
      r.data = DATA_WIDTH'(LIM_LO);
      r.flag = 1'b1;
    end else begin
      r.data = DATA_WIDTH'(v);
      r.flag = 1'b0;
    end
    return r;
  endfunction

  state_t state, state_nxt;

  logic [CW-1:0]         pix_cnt;
  logic [CW-1:0]         rd_ptr;
  logic [SW-1:0]         scl_cnt;
  logic [DATA_WIDTH-1:0] scale_reg [IN_CHANNELS];

  logic in_fire, scale_fire, out_fire, last_out, stall, rd_en;

  logic                  vld_p1;
  logic [CW-1:0]         idx_p1;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic [CW-1:0]         idx_p2;

  logic [CHW-1:0]        ch_p1;
  logic [DATA_WIDTH-1:0] scale_sel;
  logic signed [PW-1:0]  prod_p1;
  sat_t                  res_p1;

  assign in_ready    = (state == FILL);
  assign scale_ready = (state != EMIT) && (scl_cnt < SW'(IN_CHANNELS));
  assign in_fire     = in_ready && in_valid;
  assign scale_fire  = scale_ready && scale_valid;
  assign out_fire    = out_valid && out_ready;
  assign last_out    = out_fire && (idx_p2 == CW'(TOTAL_PIXELS - 1));
  // A held output freezes every stage, including the RAM read register.
  assign stall       = out_valid && !out_ready;
  assign rd_en       = (state == EMIT) && (rd_ptr < CW'(TOTAL_PIXELS)) && !stall;

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:       if (in_fire && (pix_cnt == CW'(TOTAL_PIXELS - 1))) state_nxt = WAIT_SCALE;
      WAIT_SCALE: if (scl_cnt == SW'(IN_CHANNELS)) state_nxt = EMIT;
      EMIT:       if (last_out) state_nxt = FILL;
      default:    state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt <= '0;
      scl_cnt <= '0;
      rd_ptr  <= '0;
      for (int i = 0; i < IN_CHANNELS; i++) scale_reg[i] <= '0;
    end else if (last_out) begin
      pix_cnt <= '0;
      scl_cnt <= '0;
      rd_ptr  <= '0;
    end else begin
      if (in_fire) pix_cnt <= pix_cnt + 1'b1;
      if (scale_fire) begin
        scale_reg[CHW'(scl_cnt)] <= scale_data;
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  se_fmap_buffer #(
    .DEPTH(TOTAL_PIXELS),
    .WIDTH(DATA_WIDTH),
    .AW   (AW)
  ) u_buf (
    .clk    (clk),
    .wr_en  (in_fire),
    .wr_addr(AW'(pix_cnt)),
    .wr_data(in_data),
    .rd_en  (rd_en),
    .rd_addr(AW'(rd_ptr)),
    .rd_data(rd_data_p1)
  );

  // Stage p1: RAM output with its frame index; select the channel scale.
  always_comb begin
    ch_p1     = CHW'(idx_p1 / CW'(PIX_PER_CH));
    scale_sel = scale_reg[ch_p1];
    // Scale is unsigned: zero-extend before the signed multiply.
    prod_p1   = PW'($signed(rd_data_p1)) * PW'($signed({1'b0, scale_sel}));
    res_p1    = saturate(floor_shift(prod_p1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1     <= 1'b0;
      idx_p1     <= '0;
      out_valid  <= 1'b0;
      idx_p2     <= '0;
      out_data   <= '0;
      sat_flag   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_out;
      if (!stall) begin
        vld_p1    <= rd_en;
        idx_p1    <= rd_ptr;
        // Stage p2: registered, saturated product.
        out_valid <= vld_p1;
        idx_p2    <= idx_p1;
        if (vld_p1) begin
          out_data <= res_p1.data;
          sat_flag <= res_p1.flag;
        end
      end
    end
  end

endmodule

// File: tb/tb_se_channel_scale.sv
module tb_se_channel_scale;

  localparam int N   = 1024;
  localparam int NCH = 16;
  localparam int PPC = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] scale_data = '0;
  logic        scale_valid = 1'b0;
  logic        scale_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sat_flag;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] smp   [N];
  logic [15:0] scl   [NCH];
  logic [15:0] exp_d [N];
  logic        exp_s [N];

  always #5 clk = ~clk;

  se_channel_scale dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .scale_data (scale_data),
    .scale_valid(scale_valid),
    .scale_ready(scale_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sat_flag   (sat_flag),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Identity frame: samples 100+(p%16), all scales 1.0.
  task automatic setup_identity();
    for (int p = 0; p < N; p++) begin
      smp[p]   = 16'(100 + (p % 16));
      exp_d[p] = 16'(100 + (p % 16));
      exp_s[p] = 1'b0;
    end
    for (int c = 0; c < NCH; c++) scl[c] = 16'd256;
  endtask

  // Per-channel arithmetic cases with hand-computed results.
  task automatic setup_arith();
    setup_identity();
    for (int p = 0; p < N; p++) begin
      case (p / PPC)
        0: begin smp[p] = 16'd100;  exp_d[p] = 16'd50;   exp_s[p] = 1'b0; end
        1: begin smp[p] = 16'hFFFD; exp_d[p] = 16'hFFFE; exp_s[p] = 1'b0; end
        2: begin smp[p] = 16'h7FFF; exp_d[p] = 16'h7FFF; exp_s[p] = 1'b1; end
        3: begin smp[p] = 16'h8000; exp_d[p] = 16'h8000; exp_s[p] = 1'b1; end
        4: begin smp[p] = 16'h7FFF; exp_d[p] = 16'h7FFF; exp_s[p] = 1'b0; end
        5: begin smp[p] = 16'h8000; exp_d[p] = 16'h8000; exp_s[p] = 1'b0; end
        default: ;
      endcase
    end
    scl[0] = 16'd128;
    scl[1] = 16'd128;
    scl[2] = 16'd512;
    scl[3] = 16'd512;
  endtask

  task automatic fill_frame(input bit extra_scale);
    for (int p = 0; p < N; p++) begin
      @(negedge clk);
      if (p == 0) check("fill_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = smp[p];
      if (p < NCH) begin
        scale_valid = 1'b1;
        scale_data  = scl[p];
      end else if (p == NCH && extra_scale) begin
        check("scale_ready_17th", 32'(scale_ready), 32'd0);
        scale_valid = 1'b1;
        scale_data  = 16'h0001;
      end else begin
        scale_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid    = 1'b0;
    scale_valid = 1'b0;
    in_data     = '0;
    check("in_ready_after_fill", 32'(in_ready), 32'd0);
  endtask

  task automatic emit_frame(input bit rnd, input int abort_at, input bit chk_lat);
    int k = 0;
    int cyc = 1;
    int first = -1;
    int lastcyc = 0;
    int fd = 0;
    bit held = 0;
    bit rdy;
    logic [15:0] hd = '0;
    logic hs = 1'b0;
    while (k < N && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(hd));
        check("stall_sat", 32'(sat_flag), 32'(hs));
      end
      held = 0;
      if (frame_done) fd++;
      if (out_valid && first < 0) first = cyc;
      if (abort_at >= 0 && k == abort_at) return;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (out_valid) begin
        if (rdy) begin
          check("out_data", 32'(out_data), 32'(exp_d[k]));
          check("out_sat", 32'(sat_flag), 32'(exp_s[k]));
          k++;
        end else begin
          held = 1;
          hd = out_data;
          hs = sat_flag;
        end
      end
    end
    lastcyc = cyc;
    if (k < N) check("emit_timeout", 32'(k), 32'(N));
    @(negedge clk);
    out_ready = 1'b0;
    if (frame_done) fd++;
    check("frame_done_count", 32'(fd), 32'd1);
    check("fill_after_frame", 32'(in_ready), 32'd1);
    check("out_valid_after_frame", 32'(out_valid), 32'd0);
    if (chk_lat) begin
      check("first_valid_latency", 32'(first), 32'd4);
      check("burst_length", 32'(lastcyc - first + 1), 32'(N));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_scale_ready", 32'(scale_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_sat_flag", 32'(sat_flag), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b1;

    setup_identity();
    fill_frame(1'b1);
    emit_frame(1'b0, -1, 1'b1);

    fill_frame(1'b0);
    emit_frame(1'b1, -1, 1'b0);

    setup_arith();
    fill_frame(1'b0);
    emit_frame(1'b0, -1, 1'b0);

    setup_identity();
    fill_frame(1'b0);
    emit_frame(1'b0, 500, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_sat_flag", 32'(sat_flag), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_scale_ready", 32'(scale_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b0;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    fill_frame(1'b0);
    emit_frame(1'b0, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/se_channel_scale.md
SE_CHANNEL_SCALE -- requirements
Module: se_channel_scale

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: sample and scale width, signed Q8.8 data, unsigned Q8.8 scale.
REQ-002 SHALL have parameter FRAC_BITS, default 8: fractional bits of the scale.
REQ-003 SHALL have parameters IN_CHANNELS (16), IN_HEIGHT (8) and IN_WIDTH (8); TOTAL_PIXELS = IN_CHANNELS*IN_HEIGHT*IN_WIDTH.
REQ-004 SHALL have clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have in_data, input, DATA_WIDTH: feature-map sample, channel-major order (channel c occupies IN_HEIGHT*IN_WIDTH consecutive samples).
REQ-007 SHALL have in_valid (input, 1) and in_ready (output, 1): sample accepted when both are high.
REQ-008 SHALL have scale_data, input, DATA_WIDTH: per-channel SE attention (hsigmoid output), channel 0 first.
REQ-009 SHALL have scale_valid (input, 1) and scale_ready (output, 1): scale accepted when both are high.
REQ-010 SHALL have out_data, output, DATA_WIDTH: the scaled sample.
REQ-011 SHALL have out_valid (output, 1) and out_ready (input, 1): output accepted when both are high.
REQ-012 SHALL have sat_flag, output, 1: high together with any out_data that saturated.
REQ-013 SHALL have frame_done, output, 1: one-cycle pulse when the last output of a frame is accepted.

Function
REQ-014 SHALL use the states FILL, WAIT_SCALE and EMIT; the reset state is FILL.
REQ-015 In FILL: in_ready=1; each accepted sample is written to buffer address pix_cnt and pix_cnt increments; after accepting sample TOTAL_PIXELS-1 the block SHALL go to WAIT_SCALE on the next cycle.
REQ-016 In WAIT_SCALE and EMIT: in_ready SHALL be 0; in_valid SHALL be ignored.
REQ-017 scale_ready SHALL be 1 in FILL and WAIT_SCALE while scl_cnt < IN_CHANNELS, and 0 otherwise.
REQ-018 Each accepted scale SHALL be stored into scale register scl_cnt, and scl_cnt SHALL increment.
REQ-019 Scales SHALL be accepted concurrently with samples.
REQ-020 Transition WAIT_SCALE->EMIT SHALL occur on the cycle after scl_cnt==IN_CHANNELS; FILL->EMIT never occurs directly.
REQ-021 In EMIT: the buffer SHALL be read in order 0..TOTAL_PIXELS-1.
REQ-022 In EMIT: the read-and-multiply pipeline SHALL be two stages (registered RAM read, registered product), so first out_valid is 2 cycles after entering EMIT.
REQ-023 The pipeline SHALL stall entirely while out_valid=1 and out_ready=0; out_data and sat_flag SHALL be held stable and no sample may be lost or duplicated.
REQ-024 With out_ready held at 1, one output per cycle SHALL be produced.
REQ-025 Arithmetic: product = signed(in) * unsigned(scale[c]), 2*DATA_WIDTH+1 bits; result = product >>> FRAC_BITS (arithmetic, floor).
REQ-026 If the result exceeds 0x7FFF, out_data SHALL be 0x7FFF and sat_flag SHALL be 1; below -0x8000, out_data SHALL be 0x8000 and sat_flag SHALL be 1.
REQ-027 Channel c SHALL be output index / (IN_HEIGHT*IN_WIDTH).
REQ-028 On acceptance of output TOTAL_PIXELS-1: frame_done SHALL pulse, pix_cnt and scl_cnt SHALL clear, and the state SHALL become FILL on the next cycle.
REQ-029 out_valid SHALL be 0 in FILL and WAIT_SCALE.
REQ-030 A new frame's samples SHALL be accepted from the first FILL cycle.

Reset
REQ-031 rst low SHALL asynchronously force: state FILL; pix_cnt, scl_cnt and the read pointer 0; pipeline valids 0; out_data 0; out_valid 0; sat_flag 0; frame_done 0; scale registers 0.
REQ-032 in_ready SHALL read 1 and scale_ready SHALL read 1 during reset and after reset.
REQ-033 Reset mid-frame SHALL discard the partial frame.
REQ-034 Buffer contents SHALL not be cleared and SHALL not be observable before they are rewritten.

Structure
REQ-035 Shared package se_pkg SHALL hold: the state enum (FILL, WAIT_SCALE, EMIT), FRAC_BITS, and the saturation limits.
REQ-036 Sub-module se_fmap_buffer SHALL be a simple dual-port RAM, TOTAL_PIXELS x DATA_WIDTH, with one write port and a 1-cycle registered read with read-enable (held low during stall).
REQ-037 All control SHALL live in se_channel_scale.

Verification
REQ-038 1024 samples 100+(p%16) with all scales 256 (1.0) and out_ready=1 -> out_data == in_data in order, 1024 consecutive outputs, one frame_done.
REQ-039 Samples 100 with scales 128 -> every output 50; a sample of -3 (0xFFFD) with scale 128 -> 0xFFFE (-2, floor).
REQ-040 Sample 0x7FFF with scale 512 -> 0x7FFF and sat_flag=1; sample 0x8000 with scale 512 -> 0x8000 and sat_flag=1.
REQ-041 All 16 scales sent during FILL, 17th scale_valid asserted -> scale_ready=0, 17th ignored; EMIT starts right after the last sample.
REQ-042 Random out_ready (50%) -> outputs bit-identical to REQ-038, data stable while stalled.
REQ-043 rst low at output 500 of EMIT -> outputs 0 within the reset; after release in_ready=1; a fresh full frame completes correctly.
